// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types for the two-port single-port-RAM arbiter: port identifiers and
// the per-port request payload.
package sp_ram_arb_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } ram_req_t;

    function automatic port_id_e other_port(input port_id_e id);
        return (id == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two cores.
// Optional per-port grant counters are built when SP_RAM_ARB_GNT_CNT_EN is defined.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int MEM_AW = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_req_i,
    input  logic [31:0]       p0_addr_i,
    input  logic              p0_we_i,
    input  logic [3:0]        p0_be_i,
    input  logic [31:0]       p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [31:0]       p0_rdata_o,

    input  logic              p1_req_i,
    input  logic [31:0]       p1_addr_i,
    input  logic              p1_we_i,
    input  logic [3:0]        p1_be_i,
    input  logic [31:0]       p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [31:0]       p1_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
`ifdef SP_RAM_ARB_GNT_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt0_o,
    output logic [CNT_W-1:0]  cnt1_o
`endif
);

    ram_req_t req0;
    ram_req_t req1;
    ram_req_t sel_req;

    port_id_e rr_q;
    port_id_e id_q;
    logic     valid_q;
    logic     we_q;

    logic     gnt0;
    logic     gnt1;
    logic     gnt_any;
    logic     rsp0;
    logic     rsp1;

    assign req0 = '{addr: p0_addr_i, we: p0_we_i, be: p0_be_i, wdata: p0_wdata_i};
    assign req1 = '{addr: p1_addr_i, we: p1_we_i, be: p1_be_i, wdata: p1_wdata_i};

    // Contention goes to the pointer; a lone requester wins regardless of it.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i) begin
            if (p0_req_i && (!p1_req_i || rr_q == PORT0)) begin
                gnt0 = 1'b1;
            end else if (p1_req_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign sel_req  = gnt1 ? req1 : req0;
    assign p0_gnt_o = gnt0;
    assign p1_gnt_o = gnt1;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (gnt_any) begin
            mem_en_o    = 1'b1;
            mem_we_o    = sel_req.we;
            mem_addr_o  = sel_req.addr[MEM_AW+1:2];
            mem_be_o    = sel_req.be;
            mem_wdata_o = sel_req.wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q    <= PORT0;
            id_q    <= PORT0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            valid_q <= gnt_any;
            if (gnt_any) begin
                id_q <= gnt1 ? PORT1 : PORT0;
                we_q <= sel_req.we;
                rr_q <= other_port(gnt1 ? PORT1 : PORT0);
            end
        end
    end

    // A reset landing on the response cycle drops the response outright.
    assign rsp0 = valid_q && (id_q == PORT0) && !rst_i;
    assign rsp1 = valid_q && (id_q == PORT1) && !rst_i;

    assign p0_rvalid_o = rsp0;
    assign p1_rvalid_o = rsp1;
    assign p0_rdata_o  = (rsp0 && !we_q) ? mem_rdata_i : 32'h0;
    assign p1_rdata_o  = (rsp1 && !we_q) ? mem_rdata_i : 32'h0;

`ifdef SP_RAM_ARB_GNT_CNT_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0) cnt0_q <= cnt0_q + CNT_W'(1);
            if (gnt1) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign cnt0_o = cnt0_q;
    assign cnt1_o = cnt1_q;
`endif

    // Byte-offset and above-RAM address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr_i[31:MEM_AW+2], p0_addr_i[1:0],
                                p1_addr_i[31:MEM_AW+2], p1_addr_i[1:0]};

endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter MEM_AW, default 14, word-address width of the shared single-port RAM.
REQ-002 Parameter CNT_W, default 16, width of the per-port grant counters.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 p0_req_i, p1_req_i  in  1 each  request from core 0 and core 1 LSU/fetch ports.
REQ-006 pN_addr_i  in  32  byte address; only bits [MEM_AW+1:2] are used.
REQ-007 pN_we_i  in  1 (write enable); pN_be_i  in  4 (byte enables); pN_wdata_i  in  32 (write data).
REQ-008 pN_gnt_o  out  1  request accepted this cycle.
REQ-009 pN_rvalid_o  out  1  response for that port's accepted request; pN_rdata_o  out  32  read data.
REQ-010 mem_en_o, mem_we_o  out  1 each; mem_addr_o  out  MEM_AW; mem_be_o  out  4; mem_wdata_o  out  32.
REQ-011 mem_rdata_i  in  32  RAM read data, valid exactly one cycle after mem_en_o.
REQ-012 cnt0_o, cnt1_o  out  CNT_W each  grant counters; present only under the macro in REQ-028.

Function
REQ-013 At most one port SHALL be granted per cycle; gnt SHALL be combinational from req and the priority pointer.
REQ-014 Single requester: that port SHALL be granted in the same cycle.
REQ-015 Both requesting: the port named by the round-robin pointer rr_q SHALL be granted; after any grant rr_q SHALL point to the other port.
REQ-016 mem_en_o SHALL equal (p0_gnt_o | p1_gnt_o); mem_we/addr/be/wdata SHALL be muxed from the granted port, and SHALL be 0 when no grant.
REQ-017 A one-bit-deep response pipeline (valid_q, id_q) SHALL record each grant; pN_rvalid_o SHALL assert exactly one cycle after the grant, for the granted port only.
REQ-018 rvalid SHALL assert for writes as well as reads; rdata_o SHALL carry mem_rdata_i on reads and 0 on writes and when rvalid is low.
REQ-019 Back-to-back grants SHALL be sustained: one access per cycle, no idle bubble.
REQ-020 A requester SHALL hold req and payload stable until gnt; the arbiter SHALL NOT depend on payload stability after gnt.
REQ-021 A port whose req drops before gnt SHALL lose its slot without state change to rr_q.
REQ-022 Starvation bound: with both ports requesting continuously, each port SHALL be granted at least once every 2 cycles.

Reset
REQ-023 While rst_i is high: all gnt, rvalid, mem_en_o outputs SHALL be 0 in that cycle regardless of req.
REQ-024 On reset: rr_q SHALL become port 0, valid_q 0, id_q 0, and counters 0.
REQ-025 Reset asserted in the cycle after a grant SHALL suppress the pending rvalid; the response is dropped.
REQ-026 First cycle after rst_i falls with both requesting, port 0 SHALL be granted.

Configuration
REQ-027 Feature macro: SP_RAM_ARB_GNT_CNT_EN.
REQ-028 Defined: cnt0_o/cnt1_o exist; each increments by 1 per grant to its port, wraps from 2^CNT_W-1 to 0, resets to 0.
REQ-029 Not defined: counter ports and registers are absent; all other behaviour is identical.

Structure
REQ-030 Package sp_ram_arb_pkg SHALL hold the port-id typedef (PORT0=0, PORT1=1) and the request struct (addr, we, be, wdata).
REQ-031 No sub-module is required; the counter under REQ-028 SHALL be inline logic.

Verification
REQ-032 Reset then p0 read of 0x0000_0010 alone -> p0_gnt same cycle, mem_addr_o=4, p0_rvalid next cycle with RAM word 4.
REQ-033 Both request continuously for 6 cycles -> grants P0,P1,P0,P1,P0,P1; rvalid one cycle behind each; no bubble.
REQ-034 p1 writes 0xDEADBEEF be=4'b0011 to 0x20, then p0 reads 0x20 -> p0_rdata 0x0000BEEF (prior RAM contents 0); p1_rvalid with rdata 0.
REQ-035 Grant to p1 at cycle N, rst_i high at N+1 -> p1_rvalid stays 0; after reset, both requesting -> p0 granted first.
REQ-036 With SP_RAM_ARB_GNT_CNT_EN, CNT_W=4, 17 grants to p0 -> cnt0_o=1, cnt1_o=0; without macro, same bench compiles minus counter checks.
